calc_port_driver: RTL and testbench
===================================

Name: calc_port_driver

Overview:
- Upstream stage of one calc1_top request port.
- Accepts a complete operation (cmd, operand1, operand2) on a valid/ready interface and serialises it onto req_cmd/req_data over two cycles.
- Watches out_resp for a completion, with a bounded wait.
- Returns resp/data/tag on a valid/ready result interface. One instance per port (4 per calculator).

Parameters:
TIMEOUT_CYCLES, 10, WAIT cycles allowed for a response before giving up (min 2)
TAG_W, 4, width of the opaque transaction tag carried from op to result
CNT_W, 16, width of the saturating statistics counters

Ports:
c_clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
op_valid  in  1  operation offered
op_ready  out  1  driver can accept an operation
op_cmd  in  4  calculator command (0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid)
op_param1  in  32  operand1
op_param2  in  32  operand2
op_tag  in  TAG_W  opaque tag
req_cmd_out  out  4  to calc1_top reqN_cmd_in
req_data_out  out  32  to calc1_top reqN_data_in
calc_resp  in  2  from calc1_top out_respN (0 none, 1 ok, 2 over/underflow, 3 invalid)
calc_data  in  32  from calc1_top out_dataN
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_resp  out  2  captured response code
res_data  out  32  captured data (0 when no response)
res_tag  out  TAG_W  tag of the completed op
res_timeout  out  1  non-no-op command got no response within TIMEOUT_CYCLES
issued_cnt  out  CNT_W  operations sent, saturating
timeout_cnt  out  CNT_W  timeouts, saturating

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0 except op_ready=1; counters 0; operation and result registers cleared. Reset mid-operation abandons the op with no result produced; req_* return to 0 immediately.
- States: IDLE, SEND1, SEND2, WAIT, DONE. All outputs come from registers.
- IDLE: op_ready=1. If op_valid, latch cmd/param1/param2/tag and go to SEND1. issued_cnt increments on this accept.
- SEND1 (1 cycle): req_cmd_out=cmd, req_data_out=param1. Go to SEND2.
- SEND2 (1 cycle): req_cmd_out=0, req_data_out=param2. Clear the wait counter. Go to WAIT.
- WAIT:
  - req_cmd_out=0, req_data_out=0. Sample calc_resp each cycle; the wait counter increments per WAIT cycle.
  - calc_resp is ignored in SEND1/SEND2.
  - Nonzero calc_resp, cmd!=0: capture resp/data, res_timeout=0, go to DONE.
  - Nonzero calc_resp, cmd==0 (spurious response): capture resp/data, go to DONE immediately, res_timeout=0.
  - Counter reaches TIMEOUT_CYCLES with no response:
    - cmd!=0: res_resp=0, res_data=0, res_timeout=1; timeout_cnt increments.
    - cmd==0: res_resp=0, res_timeout=0 (normal no-op completion).
  - A response and expiry in the same cycle: the response wins.
- DONE: res_valid=1 with res_* stable. On res_ready, go to IDLE with res_valid=0 on the next cycle. No skid: a new op is accepted only in IDLE.
- Best-case throughput: one op per 4 + latency cycles.
- Minimum op-accept to res_valid: 4 cycles (accept, SEND1, SEND2, WAIT with response on its first cycle, then DONE).
- Widths: the wait counter is $clog2(TIMEOUT_CYCLES+1) bits. Statistics counters stick at all-ones. No arithmetic is done on operands; they pass through unchanged.
- op_valid is not required to remain asserted when op_ready=0; no input is sampled outside IDLE.

Decomposition:
- calc_pkg:
  - cmd_e (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6)
  - resp_e (RESP_NONE=0, RESP_OK=1, RESP_FLOW=2, RESP_INVALID=3)
  - drv_state_e
  - packed op_t {cmd, param1, param2, tag}
  - packed res_t {resp, data, tag, timeout}
- Sub-module calc_sat_counter (parameterised width, inc, saturate), instanced twice for issued_cnt and timeout_cnt.
- FSM and wait counter stay in calc_port_driver.

Test Plan:
- Reset held low 3 cycles, then released → op_ready=1, res_valid=0, req_cmd_out=0, both counters 0.
- op add 5, 1, tag 3; DUT calc1_top → SEND1 drives cmd 1 / data 5; SEND2 drives cmd 0 / data 1; res_resp=1, res_data=6, res_tag=3, res_timeout=0; issued_cnt=1.
- op add FFFFFFFF, 1; then sub 22h, 23h → res_resp=2 both times; timeout_cnt stays 0.
- cmd 0 with 64h, 27h → res_valid exactly TIMEOUT_CYCLES cycles after entering WAIT; res_resp=0, res_timeout=0. Then a stub that never responds to cmd 1 → res_timeout=1, timeout_cnt=1.
- Hold res_ready=0 for 5 cycles after res_valid → res_* stable, op_ready=0, second op_valid not accepted; res_ready=1 → IDLE next cycle, then the second op is accepted.
- Assert reset during WAIT, then release → no result emitted, req_* go to 0 asynchronously, the next op completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator request-port driver: command/response codes,
// FSM encoding and packed operation/result payloads.
package calc_pkg;

    localparam int unsigned CMD_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RESP_W    = 2;
    localparam int unsigned TAG_MAX_W = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_FLOW    = 2'd2,
        RESP_INVALID = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        DRV_IDLE  = 3'd0,
        DRV_SEND1 = 3'd1,
        DRV_SEND2 = 3'd2,
        DRV_WAIT  = 3'd3,
        DRV_DONE  = 3'd4
    } drv_state_e;

    // Tag fields are sized for the widest supported TAG_W; unused upper bits stay zero.
    typedef struct packed {
        logic [CMD_W-1:0]     cmd;
        logic [DATA_W-1:0]    param1;
        logic [DATA_W-1:0]    param2;
        logic [TAG_MAX_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [RESP_W-1:0]    resp;
        logic [DATA_W-1:0]    data;
        logic [TAG_MAX_W-1:0] tag;
        logic                 timeout;
    } res_t;

endpackage

// File: rtl/calc_port_driver_if.sv
// Operation-in / result-out handshake bundle of one calculator port driver.
interface calc_port_if
    import calc_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) ();

    logic              op_valid;
    logic              op_ready;
    logic [CMD_W-1:0]  op_cmd;
    logic [DATA_W-1:0] op_param1;
    logic [DATA_W-1:0] op_param2;
    logic [TAG_W-1:0]  op_tag;

    logic              res_valid;
    logic              res_ready;
    logic [RESP_W-1:0] res_resp;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_timeout;

    // Producer/consumer side of the driver.
    modport master (
        output op_valid, op_cmd, op_param1, op_param2, op_tag, res_ready,
        input  op_ready, res_valid, res_resp, res_data, res_tag, res_timeout
    );

    // Driver side.
    modport slave (
        input  op_valid, op_cmd, op_param1, op_param2, op_tag, res_ready,
        output op_ready, res_valid, res_resp, res_data, res_tag, res_timeout
    );

endinterface

// File: rtl/calc_sat_counter.sv
// Saturating up-counter: increments on inc and holds once it reaches all-ones.
module calc_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/calc_port_driver.sv
// Upstream driver of one calc1_top request port: serialises an operation over two
// cycles, waits (bounded) for the response and returns it with its tag.
module calc_port_driver
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10,
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              c_clk,
    input  logic              reset,
    calc_port_if.slave        bus,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [RESP_W-1:0] calc_resp,
    input  logic [DATA_W-1:0] calc_data,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  timeout_cnt
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = DRV_IDLE;
    localparam logic [2:0] S_SEND1 = DRV_SEND1;
    localparam logic [2:0] S_SEND2 = DRV_SEND2;
    localparam logic [2:0] S_WAIT  = DRV_WAIT;
    localparam logic [2:0] S_DONE  = DRV_DONE;

    logic [2:0]        state_q, state_d;
    op_t               op_q, op_d;
    res_t              res_q, res_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CMD_W-1:0]  req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              op_ready_q, op_ready_d;
    logic              res_valid_q, res_valid_d;
    logic              issue_inc;
    logic              tmo_inc;

    // Next state, next registered outputs and payload capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_d      = res_q;
        wcnt_d     = wcnt_q;
        req_cmd_d  = '0;
        req_data_d = '0;
        issue_inc  = 1'b0;
        tmo_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    op_d.cmd    = bus.op_cmd;
                    op_d.param1 = bus.op_param1;
                    op_d.param2 = bus.op_param2;
                    op_d.tag    = TAG_MAX_W'(bus.op_tag);
                    req_cmd_d   = bus.op_cmd;
                    req_data_d  = bus.op_param1;
                    issue_inc   = 1'b1;
                    state_d     = S_SEND1;
                end
            end
            S_SEND1: begin
                req_data_d = op_q.param2;
                state_d    = S_SEND2;
            end
            S_SEND2: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving on the expiry cycle still counts as a response.
                if (calc_resp != RESP_NONE) begin
                    res_d.resp    = calc_resp;
                    res_d.data    = calc_data;
                    res_d.tag     = op_q.tag;
                    res_d.timeout = 1'b0;
                    state_d       = S_DONE;
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d.resp    = RESP_NONE;
                    res_d.data    = '0;
                    res_d.tag     = op_q.tag;
                    res_d.timeout = (op_q.cmd != CMD_NOP);
                    tmo_inc       = (op_q.cmd != CMD_NOP);
                    state_d       = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        op_ready_d  = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            res_q       <= '0;
            wcnt_q      <= '0;
            req_cmd_q   <= '0;
            req_data_q  <= '0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            wcnt_q      <= wcnt_d;
            req_cmd_q   <= req_cmd_d;
            req_data_q  <= req_data_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_cmd_out     = req_cmd_q;
    assign req_data_out    = req_data_q;
    assign bus.op_ready    = op_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_resp    = res_q.resp;
    assign bus.res_data    = res_q.data;
    assign bus.res_tag     = TAG_W'(res_q.tag);
    assign bus.res_timeout = res_q.timeout;

    // param1 leaves via req_data directly at accept; tag upper bits are always zero.
    logic unused_bits;
    assign unused_bits = ^{op_q.param1, res_q.tag};

    calc_sat_counter #(.WIDTH(CNT_W)) u_issued_cnt (
        .clk   (c_clk),
        .rst_n (reset),
        .inc   (issue_inc),
        .count (issued_cnt)
    );

    calc_sat_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
        .clk   (c_clk),
        .rst_n (reset),
        .inc   (tmo_inc),
        .count (timeout_cnt)
    );

endmodule

// File: tb/tb_calc_port_driver.sv
// Directed self-checking bench for calc_port_driver with a hand-driven calc1_top
// response stub.
module tb_calc_port_driver;

    logic        c_clk;
    logic        reset;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  calc_resp;
    logic [31:0] calc_data;
    logic [15:0] issued_cnt;
    logic [15:0] timeout_cnt;

    int n_assert;
    int n_fail;
    int lat;

    calc_port_if #(.TAG_W(4)) bus ();

    calc_port_driver #(
        .TIMEOUT_CYCLES (10),
        .TAG_W          (4),
        .CNT_W          (16)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .bus          (bus),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .calc_resp    (calc_resp),
        .calc_data    (calc_data),
        .issued_cnt   (issued_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // Offer an op while IDLE; returns just after the accepting edge (SEND1).
    task automatic accept_only(input logic [3:0] cmd, input logic [31:0] p1, input logic [31:0] p2,
                               input logic [3:0] tag);
        chk("idle_op_ready", 64'(bus.op_ready), 64'(1));
        bus.op_valid  = 1'b1;
        bus.op_cmd    = cmd;
        bus.op_param1 = p1;
        bus.op_param2 = p2;
        bus.op_tag    = tag;
        step();
        bus.op_valid  = 1'b0;
        bus.op_cmd    = 4'hF;
        bus.op_param1 = 32'h5A5A_5A5A;
        bus.op_param2 = 32'hA5A5_A5A5;
        bus.op_tag    = 4'hF;
    endtask

    // From SEND1: check serialisation, answer at WAIT cycle resp_at (-1 = never), wait for res_valid.
    task automatic finish_op(input logic [3:0] cmd, input logic [31:0] p1, input logic [31:0] p2,
                             input int resp_at, input logic [1:0] resp, input logic [31:0] data,
                             output int cycles);
        chk("send1_cmd", 64'(req_cmd_out), 64'(cmd));
        chk("send1_data", 64'(req_data_out), 64'(p1));
        chk("send1_op_ready", 64'(bus.op_ready), 64'(0));
        calc_resp = 2'd3;
        calc_data = 32'hBAD0_0000;
        step();
        chk("send2_cmd", 64'(req_cmd_out), 64'(0));
        chk("send2_data", 64'(req_data_out), 64'(p2));
        step();
        chk("wait_cmd", 64'(req_cmd_out), 64'(0));
        chk("wait_data", 64'(req_data_out), 64'(0));
        cycles = 0;
        while (bus.res_valid !== 1'b1 && cycles < 40) begin
            if (cycles == resp_at) begin
                calc_resp = resp;
                calc_data = data;
            end else begin
                calc_resp = 2'd0;
                calc_data = 32'hDEAD_BEEF;
            end
            step();
            cycles++;
        end
        calc_resp = 2'd0;
        calc_data = 32'h0;
        chk("res_valid_seen", 64'(bus.res_valid), 64'(1));
    endtask

    task automatic send_op(input logic [3:0] cmd, input logic [31:0] p1, input logic [31:0] p2,
                           input logic [3:0] tag, input int resp_at, input logic [1:0] resp,
                           input logic [31:0] data, output int cycles);
        accept_only(cmd, p1, p2, tag);
        finish_op(cmd, p1, p2, resp_at, resp, data, cycles);
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("released_res_valid", 64'(bus.res_valid), 64'(0));
        chk("released_op_ready", 64'(bus.op_ready), 64'(1));
    endtask

    task automatic chk_res(input string tag, input logic [1:0] resp, input logic [31:0] data,
                           input logic [3:0] rtag, input logic tmo);
        chk({tag, "_resp"}, 64'(bus.res_resp), 64'(resp));
        chk({tag, "_data"}, 64'(bus.res_data), 64'(data));
        chk({tag, "_tag"}, 64'(bus.res_tag), 64'(rtag));
        chk({tag, "_timeout"}, 64'(bus.res_timeout), 64'(tmo));
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_cmd    = 4'h0;
        bus.op_param1 = 32'h0;
        bus.op_param2 = 32'h0;
        bus.op_tag    = 4'h0;
        bus.res_ready = 1'b0;
        calc_resp     = 2'd0;
        calc_data     = 32'h0;

        // Reset held for 3 cycles, then released.
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_op_ready", 64'(bus.op_ready), 64'(1));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_req_cmd", 64'(req_cmd_out), 64'(0));
        chk("rst_req_data", 64'(req_data_out), 64'(0));
        chk("rst_issued", 64'(issued_cnt), 64'(0));
        chk("rst_timeouts", 64'(timeout_cnt), 64'(0));

        // add 5+1, answered on the first WAIT cycle: minimum latency.
        send_op(4'd1, 32'd5, 32'd1, 4'd3, 0, 2'd1, 32'd6, lat);
        chk("add_latency", 64'(lat), 64'(1));
        chk_res("add", 2'd1, 32'd6, 4'd3, 1'b0);
        chk("add_issued", 64'(issued_cnt), 64'(1));
        take_result();

        // Overflow then underflow responses.
        send_op(4'd1, 32'hFFFF_FFFF, 32'd1, 4'd7, 2, 2'd2, 32'h0, lat);
        chk("ovf_latency", 64'(lat), 64'(3));
        chk_res("ovf", 2'd2, 32'h0, 4'd7, 1'b0);
        take_result();
        send_op(4'd2, 32'h22, 32'h23, 4'd8, 0, 2'd2, 32'hFFFF_FFFF, lat);
        chk_res("udf", 2'd2, 32'hFFFF_FFFF, 4'd8, 1'b0);
        chk("udf_timeouts", 64'(timeout_cnt), 64'(0));
        chk("udf_issued", 64'(issued_cnt), 64'(3));
        take_result();

        // No-op with no response completes normally after the full wait.
        send_op(4'd0, 32'h64, 32'h27, 4'd1, -1, 2'd0, 32'h0, lat);
        chk("nop_latency", 64'(lat), 64'(10));
        chk_res("nop", 2'd0, 32'h0, 4'd1, 1'b0);
        chk("nop_timeouts", 64'(timeout_cnt), 64'(0));
        take_result();

        // Real command with no response times out.
        send_op(4'd1, 32'h10, 32'h20, 4'd2, -1, 2'd0, 32'h0, lat);
        chk("tmo_latency", 64'(lat), 64'(10));
        chk_res("tmo", 2'd0, 32'h0, 4'd2, 1'b1);
        chk("tmo_timeouts", 64'(timeout_cnt), 64'(1));
        take_result();

        // Response on the last WAIT cycle beats expiry.
        send_op(4'd5, 32'h3, 32'h2, 4'd4, 9, 2'd1, 32'hC, lat);
        chk("late_latency", 64'(lat), 64'(10));
        chk_res("late", 2'd1, 32'hC, 4'd4, 1'b0);
        chk("late_timeouts", 64'(timeout_cnt), 64'(1));
        take_result();

        // Spurious response to a no-op is captured.
        send_op(4'd0, 32'h1, 32'h1, 4'hA, 2, 2'd3, 32'h99, lat);
        chk("spur_latency", 64'(lat), 64'(3));
        chk_res("spur", 2'd3, 32'h99, 4'hA, 1'b0);
        chk("spur_issued", 64'(issued_cnt), 64'(7));
        take_result();

        // Result back-pressure with a second op pending.
        send_op(4'd1, 32'd10, 32'd20, 4'd5, 1, 2'd1, 32'd30, lat);
        chk("bp_latency", 64'(lat), 64'(2));
        bus.op_valid  = 1'b1;
        bus.op_cmd    = 4'd2;
        bus.op_param1 = 32'd9;
        bus.op_param2 = 32'd4;
        bus.op_tag    = 4'd6;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_res_valid", 64'(bus.res_valid), 64'(1));
            chk("bp_op_ready", 64'(bus.op_ready), 64'(0));
            chk_res("bp_hold", 2'd1, 32'd30, 4'd5, 1'b0);
            chk("bp_issued", 64'(issued_cnt), 64'(8));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("bp_release_valid", 64'(bus.res_valid), 64'(0));
        chk("bp_release_ready", 64'(bus.op_ready), 64'(1));
        chk("bp_release_issued", 64'(issued_cnt), 64'(8));
        step();
        bus.op_valid = 1'b0;
        chk("bp_second_issued", 64'(issued_cnt), 64'(9));
        finish_op(4'd2, 32'd9, 32'd4, 0, 2'd1, 32'd5, lat);
        chk_res("bp_second", 2'd1, 32'd5, 4'd6, 1'b0);
        take_result();

        // Reset during SEND1 clears req_* without a clock edge.
        accept_only(4'd1, 32'hAAAA_5555, 32'h1234, 4'd2);
        chk("pre_rst_cmd", 64'(req_cmd_out), 64'(1));
        reset = 1'b0;
        #1;
        chk("async_rst_cmd", 64'(req_cmd_out), 64'(0));
        chk("async_rst_data", 64'(req_data_out), 64'(0));
        chk("async_rst_issued", 64'(issued_cnt), 64'(0));
        step();
        reset = 1'b1;
        step();

        // Reset during WAIT abandons the op; no result appears.
        accept_only(4'd1, 32'd1, 32'd2, 4'd3);
        step();
        step();
        calc_resp = 2'd1;
        calc_data = 32'd3;
        reset     = 1'b0;
        step();
        step();
        calc_resp = 2'd0;
        calc_data = 32'h0;
        reset     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abandon_res_valid", 64'(bus.res_valid), 64'(0));
            chk("abandon_op_ready", 64'(bus.op_ready), 64'(1));
        end
        send_op(4'd1, 32'd7, 32'd8, 4'd9, 0, 2'd1, 32'd15, lat);
        chk_res("post_rst", 2'd1, 32'd15, 4'd9, 1'b0);
        chk("post_rst_issued", 64'(issued_cnt), 64'(1));
        take_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
